instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction packer and program loader that does the inverse of the instruction decoder. It accepts field-level instruction beats (op, mode, src, dst, litsrc) over a valid/ready handshake and packs each into the 49-bit instruction word. It then streams the words into instruction memory at consecutive addresses from a programmable base. It sits between the test/boot program source and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction memory address width
- DEPTH, 256, maximum beats per program load (1..2^ADDR_W)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a program load; sampled only in IDLE or ERR
- base_addr  in  ADDR_W  first write address, captured when start is taken
- in_valid  in  1  beat present
- in_ready  out  1  encoder can take a beat; combinational from state (1 only in LOAD)
- op  in  5  opcode field
- mode  in  2  addressing mode field
- src  in  5  source register field
- dst  in  5  destination register field
- litsrc  in  32  literal/source field
- last  in  1  beat is the final instruction of the program
- imem_we  out  1  instruction memory write strobe (registered)
- imem_addr  out  ADDR_W  write address (registered)
- imem_wdata  out  49  packed instruction (registered)
- count  out  ADDR_W+1  words written since the last start
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse on the final write of a program
- overflow  out  1  sticky; DEPTH beats accepted without last

## Operation
- Packing: imem_wdata = {op, mode, src, dst, litsrc}. op occupies [48:44], mode [43:42], src [41:37], dst [36:32], litsrc [31:0]. No field checking.
- Beat accepted when in_valid && in_ready.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: if start is high, load ptr = base_addr, clear count and overflow, and go to LOAD.
- LOAD: each accepted beat is registered, and ptr increments by 1 modulo 2^ADDR_W (wrap, no error).
  - Accepted beat with last=1: go to DONE.
  - Accepted beat that is the DEPTH-th since start and has last=0: go to ERR.
  - start is ignored.
- DONE: lasts one cycle; the final write occurs, done=1, then go to IDLE. in_ready=0.
- ERR: the DEPTH-th beat is still written. overflow=1, in_ready=0, busy=0. Only start leaves ERR; it behaves as in IDLE and clears overflow.
- DEPTH-th beat with last=1: normal DONE path, no overflow.
- count increments with every imem_we and saturates at DEPTH.
- When imem_we=0, imem_addr and imem_wdata hold their last values.
- Reset from any state (including mid-load) gives state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, busy=0, done=0, overflow=0. Pending writes are discarded; the source must restart the load.

## Timing
- Latency: a beat accepted at edge N is written with imem_we=1 in cycle N+1, using the address ptr held at acceptance.
- Throughput: one beat per cycle in LOAD. Back-to-back accepts produce back-to-back writes at contiguous addresses. Gaps in in_valid produce gaps in imem_we with no address skip.
- in_ready rises the cycle after start is taken in IDLE or ERR.
- in_ready falls the cycle after the accept of a last beat or the DEPTH-th beat.
- done is coincident with the final imem_we.
- busy falls the cycle after done.
- A new start is accepted the cycle after done.

## Test plan
- Reset: hold rst for 2 cycles with random inputs. Every output must be 0, and in_ready=0.
- Single-beat load: start with base 0x10, then one beat with op=0x03, mode=1, src=0x02, dst=0x04, litsrc=0xDEADBEEF, last=1. Required next cycle: imem_we=1, imem_addr=0x10, imem_wdata=49'h0_3444_DEAD_BEEF, done=1, count=1. The cycle after that: busy=0.
- Burst with bubbles: base 0x20, 4 beats with in_valid low for 2 cycles between beats 2 and 3. Writes must land at 0x20–0x23 in order, each one cycle after its accept, and no imem_we during the bubbles.
- Wrap: ADDR_W=4, base 0xE, 4 beats with the last flagged. Writes go to 0xE, 0xF, 0x0, 0x1; overflow=0; done=1 on the write to 0x1.
- Overflow: DEPTH=4, 5 beats offered with none flagged last. Exactly 4 writes occur and overflow=1. in_ready=0 from the cycle after the 4th accept, and the 5th beat is never accepted. A following start clears overflow and reloads base.
- start mid-load: pulse start during LOAD with a different base_addr. It is ignored: addresses continue contiguously from the original base, and count is not cleared.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction beats into 49-bit words and
// streams them into instruction memory at consecutive addresses from a base.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [1:0]        mode,
  input  logic [4:0]        src,
  input  logic [4:0]        dst,
  input  logic [31:0]       litsrc,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [48:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              take_start;
  logic              at_limit;

  // count equals beats accepted so far, so the DEPTH-th accept is when count hits DEPTH-1
  assign accept     = in_valid && (state == LOAD);
  assign take_start = start && ((state == IDLE) || (state == ERR));
  assign at_limit   = (count == DEPTH_LAST);

  // Next-state and state-decoded handshake/status outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (last)          state_nxt = DONE;
          else if (at_limit) state_nxt = ERR;
        end
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write port, pointer, word counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
    end else begin
      imem_we <= accept;
      done    <= accept && last;
      if (take_start) begin
        ptr      <= base_addr;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (accept) begin
        imem_addr  <= ptr;
        imem_wdata <= {op, mode, src, dst, litsrc};
        ptr        <= ptr + PTR_ONE;
        if (count != DEPTH_C) count <= count + CNT_ONE;
        if (!last && at_limit) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table vectors, hand-written corner
// sequences on a small (ADDR_W=4, DEPTH=4) instance, and randomized loads.
module tb_instr_encoder;

  localparam int unsigned AW  = 8;
  localparam int unsigned DP  = 256;
  localparam int unsigned AWS = 4;
  localparam int unsigned DPS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_s;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic [4:0]    op, src, dst;
  logic [1:0]    mode;
  logic [31:0]   litsrc;
  logic          last;

  logic          in_ready, imem_we, busy, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [48:0]   imem_wdata;
  logic [AW:0]   count;

  logic           s_in_ready, s_imem_we, s_busy, s_done, s_overflow;
  logic [AWS-1:0] s_imem_addr;
  logic [48:0]    s_imem_wdata;
  logic [AWS:0]   s_count;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .mode(mode),
    .src(src), .dst(dst), .litsrc(litsrc), .last(last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .overflow(overflow)
  );

  instr_encoder #(.ADDR_W(AWS), .DEPTH(DPS)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .base_addr(base_addr[AWS-1:0]),
    .in_valid(in_valid), .in_ready(s_in_ready), .op(op), .mode(mode),
    .src(src), .dst(dst), .litsrc(litsrc), .last(last),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .count(s_count), .busy(s_busy), .done(s_done), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [4:0]  op;
    logic [1:0]  mode;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [31:0] lit;
    logic [7:0]  exp_a;
    logic [48:0] exp_w;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference packing from field positions as plain arithmetic
  function automatic logic [48:0] packw(input longint unsigned o, input longint unsigned m,
                                        input longint unsigned s, input longint unsigned d,
                                        input longint unsigned l);
    longint unsigned v;
    v = o * (64'd1 << 44) + m * (64'd1 << 42) + s * (64'd1 << 37) + d * (64'd1 << 32) + l;
    return v[48:0];
  endfunction

  task automatic idle_inputs;
    start = 1'b0; start_s = 1'b0; in_valid = 1'b0; last = 1'b0;
    op = '0; mode = '0; src = '0; dst = '0; litsrc = '0; base_addr = '0;
  endtask

  task automatic rand_fields;
    op = 5'($urandom); mode = 2'($urandom); src = 5'($urandom);
    dst = 5'($urandom); litsrc = $urandom;
  endtask

  // One program on the main instance; the model tracks readiness, addresses and count itself
  task automatic run_main(input logic [7:0] base, input int n, input int gap_at,
                          input int gap_len, input bit rnd, input bit mid);
    bit          loading, gap_done, bub, lastw;
    int          idx, gapleft, cyc;
    logic [48:0] ew;
    start = 1'b1; base_addr = base; in_valid = 1'b0;
    step;
    start = 1'b0;
    chk("start_ready", 64'(in_ready), 64'd1);
    chk("start_count", 64'(count), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    loading = 1'b1; idx = 0; gapleft = 0; gap_done = 1'b0; cyc = 0;
    while (loading && cyc < 400) begin
      cyc++;
      if (!gap_done && idx == gap_at) begin gapleft = gap_len; gap_done = 1'b1; end
      bub = (gapleft > 0) || (rnd && $urandom_range(0, 2) == 0);
      if (gapleft > 0) gapleft--;
      rand_fields();
      lastw    = (idx == n - 1);
      last     = bub ? 1'($urandom) : lastw;
      in_valid = !bub;
      start    = mid && ($urandom_range(0, 3) == 0);
      base_addr = ~base;
      ew = packw(op, mode, src, dst, litsrc);
      step;
      if (!bub) begin
        chk("w_we", 64'(imem_we), 64'd1);
        chk("w_addr", 64'(imem_addr), 64'((int'(base) + idx) % 256));
        chk("w_data", 64'(imem_wdata), 64'(ew));
        chk("w_done", 64'(done), 64'(lastw));
        chk("w_count", 64'(count), 64'(idx + 1));
        idx++;
        if (lastw) loading = 1'b0;
      end else begin
        chk("gap_we", 64'(imem_we), 64'd0);
        chk("gap_done", 64'(done), 64'd0);
        if (idx > 0) chk("gap_addr_hold", 64'(imem_addr), 64'((int'(base) + idx - 1) % 256));
        chk("gap_count", 64'(count), 64'(idx));
      end
      chk("load_ready", 64'(in_ready), 64'(loading));
      chk("load_busy", 64'(busy), 64'd1);
    end
    if (loading) chk("load_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; start = 1'b0; last = 1'b0;
    step;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_done", 64'(done), 64'd0);
    chk("end_we", 64'(imem_we), 64'd0);
    chk("end_ready", 64'(in_ready), 64'd0);
    chk("end_overflow", 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [48:0] ew;
    tbl[0] = '{8'h10, 5'h03, 2'd1, 5'h02, 5'h04, 32'hDEADBEEF, 8'h10, 49'h0_3444_DEAD_BEEF};
    tbl[1] = '{8'hFF, 5'h1F, 2'd3, 5'h1F, 5'h1F, 32'hFFFFFFFF, 8'hFF, 49'h1_FFFF_FFFF_FFFF};
    tbl[2] = '{8'h00, 5'h1F, 2'd0, 5'h00, 5'h00, 32'h00000000, 8'h00, 49'h1_F000_0000_0000};
    tbl[3] = '{8'h7F, 5'h00, 2'd3, 5'h00, 5'h00, 32'h00000000, 8'h7F, 49'h0_0C00_0000_0000};
    tbl[4] = '{8'h80, 5'h00, 2'd0, 5'h1F, 5'h00, 32'h00000000, 8'h80, 49'h0_03E0_0000_0000};
    tbl[5] = '{8'h01, 5'h00, 2'd0, 5'h00, 5'h1F, 32'h00000001, 8'h01, 49'h0_001F_0000_0001};

    // Reset with random inputs for two cycles
    rst = 1'b1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      rand_fields();
      start = 1'($urandom); start_s = 1'($urandom); in_valid = 1'($urandom);
      last = 1'($urandom); base_addr = 8'($urandom);
      step;
    end
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_s_ready", 64'(s_in_ready), 64'd0);
    chk("rst_s_we", 64'(s_imem_we), 64'd0);
    rst = 1'b0;
    idle_inputs();
    step;

    // Table of single-beat loads, back-to-back starts right after done
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; base_addr = tbl[i].base;
      step;
      start = 1'b0;
      chk("tbl_ready", 64'(in_ready), 64'd1);
      op = tbl[i].op; mode = tbl[i].mode; src = tbl[i].src; dst = tbl[i].dst;
      litsrc = tbl[i].lit; last = 1'b1; in_valid = 1'b1;
      step;
      in_valid = 1'b0; last = 1'b0;
      chk("tbl_we", 64'(imem_we), 64'd1);
      chk("tbl_addr", 64'(imem_addr), 64'(tbl[i].exp_a));
      chk("tbl_wdata", 64'(imem_wdata), 64'(tbl[i].exp_w));
      chk("tbl_done", 64'(done), 64'd1);
      chk("tbl_count", 64'(count), 64'd1);
      chk("tbl_ready_low", 64'(in_ready), 64'd0);
      chk("tbl_busy_done", 64'(busy), 64'd1);
      step;
      chk("tbl_busy_after", 64'(busy), 64'd0);
      chk("tbl_done_after", 64'(done), 64'd0);
      chk("tbl_we_after", 64'(imem_we), 64'd0);
      chk("tbl_wdata_hold", 64'(imem_wdata), 64'(tbl[i].exp_w));
    end

    // Burst with a two-cycle bubble between beats 2 and 3
    run_main(8'h20, 4, 2, 2, 1'b0, 1'b0);
    // Address wrap on the main instance
    run_main(8'hFD, 6, -1, 0, 1'b0, 1'b0);
    // start pulses during load are ignored
    run_main(8'h33, 8, -1, 0, 1'b0, 1'b1);

    // Wrap on small instance: 0xE,0xF,0x0,0x1; DEPTH-th beat carries last
    start_s = 1'b1; base_addr = 8'h0E;
    step;
    start_s = 1'b0;
    chk("wrap_ready", 64'(s_in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      rand_fields(); last = (k == 3); in_valid = 1'b1;
      ew = packw(op, mode, src, dst, litsrc);
      step;
      chk("wrap_we", 64'(s_imem_we), 64'd1);
      chk("wrap_addr", 64'(s_imem_addr), 64'((14 + k) % 16));
      chk("wrap_wdata", 64'(s_imem_wdata), 64'(ew));
      chk("wrap_done", 64'(s_done), 64'(k == 3));
      chk("wrap_count", 64'(s_count), 64'(k + 1));
      chk("wrap_ready_k", 64'(s_in_ready), 64'(k != 3));
      chk("wrap_overflow", 64'(s_overflow), 64'd0);
    end
    in_valid = 1'b0; last = 1'b0;
    step;
    chk("wrap_busy_end", 64'(s_busy), 64'd0);
    chk("wrap_overflow_end", 64'(s_overflow), 64'd0);

    // Overflow on small instance: 6 beats offered without last, only 4 taken
    start_s = 1'b1; base_addr = 8'h03;
    step;
    start_s = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rand_fields(); last = 1'b0; in_valid = 1'b1;
      ew = packw(op, mode, src, dst, litsrc);
      step;
      if (k < 4) begin
        chk("ovf_we", 64'(s_imem_we), 64'd1);
        chk("ovf_addr", 64'(s_imem_addr), 64'(3 + k));
        chk("ovf_wdata", 64'(s_imem_wdata), 64'(ew));
        chk("ovf_count", 64'(s_count), 64'(k + 1));
        chk("ovf_ready", 64'(s_in_ready), 64'(k < 3));
        chk("ovf_flag", 64'(s_overflow), 64'(k == 3));
        chk("ovf_done", 64'(s_done), 64'd0);
      end else begin
        chk("ovf_no_write", 64'(s_imem_we), 64'd0);
        chk("ovf_ready_low", 64'(s_in_ready), 64'd0);
        chk("ovf_sticky", 64'(s_overflow), 64'd1);
        chk("ovf_count_sat", 64'(s_count), 64'd4);
        chk("ovf_busy", 64'(s_busy), 64'd0);
        chk("ovf_addr_hold", 64'(s_imem_addr), 64'd6);
      end
    end
    in_valid = 1'b0;
    start_s = 1'b1; base_addr = 8'h09;
    step;
    start_s = 1'b0;
    chk("restart_overflow", 64'(s_overflow), 64'd0);
    chk("restart_count", 64'(s_count), 64'd0);
    chk("restart_ready", 64'(s_in_ready), 64'd1);
    rand_fields(); last = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0; last = 1'b0;
    chk("restart_addr", 64'(s_imem_addr), 64'd9);
    chk("restart_done", 64'(s_done), 64'd1);
    step;

    // Reset in the middle of a load
    start = 1'b1; base_addr = 8'h40;
    step;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_fields(); last = 1'b0; in_valid = 1'b1;
      step;
    end
    rst = 1'b1;
    step;
    chk("mrst_we", 64'(imem_we), 64'd0);
    chk("mrst_addr", 64'(imem_addr), 64'd0);
    chk("mrst_wdata", 64'(imem_wdata), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    rst = 1'b0; in_valid = 1'b1;
    step;
    chk("mrst_idle_ready", 64'(in_ready), 64'd0);
    chk("mrst_idle_we", 64'(imem_we), 64'd0);
    in_valid = 1'b0;
    step;

    // Randomized programs with bubbles and ignored mid-load starts
    for (int p = 0; p < 15; p++) begin
      run_main(8'($urandom), int'($urandom_range(1, 10)), -1, 0, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
